// File: rtl/melody_sequencer.sv
// Song sequencer: walks a synchronous song ROM and holds each note's half-period
// on out_note for dur x tick_len cycles, followed by a silent gap.
module melody_sequencer #(
    parameter int TICK_DIV  = 2_500_000,
    parameter int GAP_TICKS = 1,
    parameter int ADDR_W    = 5
) (
    input  logic              CLOCK_50,
    input  logic [3:0]        KEY,
    input  logic [9:0]        SW,
    input  logic [22:0]       rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [18:0]       out_note,
    output logic              playing,
    output logic              note_strobe
);

    localparam int TL_W = $clog2(TICK_DIV + 1);
    localparam int TK_W = (GAP_TICKS > 15) ? $clog2(GAP_TICKS + 1) : 4;
    localparam logic [TK_W-1:0] GAP_LAST = TK_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PLAY,
        S_GAP
    } state_t;

    function automatic logic [TL_W-1:0] calc_tick_len(input logic [1:0] shift);
        int len;
        len = TICK_DIV >> shift;
        if (len < 1) len = 1;
        return TL_W'(len);
    endfunction

    logic              rst_n;
    logic              key_p0, key_p1, key_p2;
    logic              press_evt;
    logic              unused_inputs;
    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [TL_W-1:0]   cyc;
    logic [TL_W-1:0]   tl_q;
    logic [TK_W-1:0]   tick;
    logic [3:0]        dur_q;
    logic [3:0]        rom_dur;
    logic [18:0]       rom_half;

    assign rst_n         = KEY[0];
    assign rom_dur       = rom_data[22:19];
    assign rom_half      = rom_data[18:0];
    assign unused_inputs = &{1'b0, KEY[3:2], SW[9:3]};

    // KEY[1] synchronizer; the button idles high so the flops reset released
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            key_p0 <= 1'b1;
            key_p1 <= 1'b1;
            key_p2 <= 1'b1;
        end else begin
            key_p0 <= KEY[1];
            key_p1 <= key_p0;
            key_p2 <= key_p1;
        end
    end

    assign press_evt = key_p2 & ~key_p1;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            out_note    <= '0;
            playing     <= 1'b0;
            note_strobe <= 1'b0;
            cyc         <= '0;
            tick        <= '0;
            dur_q       <= '0;
            tl_q        <= TL_W'(1);
        end else begin
            note_strobe <= 1'b0;
            // A press while active stops playback, overriding any other transition
            if (press_evt && state != S_IDLE) begin
                state    <= S_IDLE;
                idx      <= '0;
                out_note <= '0;
                playing  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        out_note <= '0;
                        idx      <= '0;
                        if (press_evt) begin
                            state   <= S_FETCH;
                            playing <= 1'b1;
                        end
                    end
                    S_FETCH: state <= S_WAIT;
                    S_WAIT: begin
                        if (rom_dur == 4'd0) begin
                            idx <= '0;
                            if (SW[0]) begin
                                state <= S_FETCH;
                            end else begin
                                state   <= S_IDLE;
                                playing <= 1'b0;
                            end
                        end else begin
                            out_note    <= rom_half;
                            note_strobe <= 1'b1;
                            dur_q       <= rom_dur;
                            tl_q        <= calc_tick_len(SW[2:1]);
                            cyc         <= '0;
                            tick        <= '0;
                            state       <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (cyc == tl_q - TL_W'(1)) begin
                            cyc <= '0;
                            if (tick == TK_W'(dur_q) - TK_W'(1)) begin
                                tick     <= '0;
                                out_note <= '0;
                                state    <= S_GAP;
                            end else begin
                                tick <= tick + 1'b1;
                            end
                        end else begin
                            cyc <= cyc + 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (GAP_TICKS == 0) begin
                            idx   <= idx + 1'b1;
                            state <= S_FETCH;
                        end else if (cyc == tl_q - TL_W'(1)) begin
                            cyc <= '0;
                            if (tick == GAP_LAST) begin
                                tick  <= '0;
                                idx   <= idx + 1'b1;
                                state <= S_FETCH;
                            end else begin
                                tick <= tick + 1'b1;
                            end
                        end else begin
                            cyc <= cyc + 1'b1;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        playing  <= 1'b0;
                        out_note <= '0;
                        idx      <= '0;
                    end
                endcase
            end
        end
    end

    assign rom_addr = idx;

endmodule
